hba_reg_file: RTL
=================

Name: hba_reg_file

Overview:
- Parametrised successor to the basic HBA register bank. Provides NUM_REGS registers, each DBUS_WIDTH wide; each register is either read/write or read-only.
- Read-only registers are driven by user logic. A change in their value raises a maskable interrupt.
- Has a programmable number of wait states before xferack, and a write strobe per register.
- Sits on the HBA slave bus beside other peripherals. Its output bus is OR-combined with theirs.

Parameters:
- DBUS_WIDTH, 8, data bus width.
- PERIPH_ADDR_WIDTH, 4, peripheral-select field width.
- REG_ADDR_WIDTH, 8, register-offset field width.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, total address width.
- PERIPH_ADDR, 0, peripheral number this block decodes.
- NUM_REGS, 4, number of data registers. Legal range 1..DBUS_WIDTH.
- RO_MASK, 0, NUM_REGS-bit mask. Bit i=1 makes register i read-only and sourced from reg_in.
- WAIT_STATES, 0, extra cycles before xferack. Legal range 0..15.

Ports:
- hba_clk  in  1  bus clock.
- hba_reset  in  1  asynchronous, active-low reset.
- hba_rnw  in  1  1=read, 0=write.
- hba_select  in  1  transfer in progress.
- hba_abus  in  ADDR_WIDTH  address.
- hba_dbus  in  DBUS_WIDTH  write data.
- regbank_dbus  out  DBUS_WIDTH  read data. 0 when not acking a read.
- regbank_xferack  out  1  transfer acknowledge, one-cycle pulse.
- regbank_interrupt  out  1  level interrupt.
- reg_out  out  NUM_REGS*DBUS_WIDTH  flattened register contents. Register i occupies bits [i*DBUS_WIDTH +: DBUS_WIDTH].
- reg_in  in  NUM_REGS*DBUS_WIDTH  user values for read-only registers. Slices of read/write registers are ignored.
- reg_wr_strobe  out  NUM_REGS  bit i pulses for one cycle when register i is written.

Behaviour:
- Reset (hba_reset=0, asynchronous):
  - All registers, int_status, int_enable, the change-detect sample and the FSM clear to 0.
  - All outputs go to 0.
  - Reset asserted mid-transfer aborts the transfer. No write commits and no xferack is issued.
- Decode:
  - hit = hba_select & (abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR).
  - idx = abus[REG_ADDR_WIDTH-1:0].
- Register map:
  - idx 0..NUM_REGS-1: data registers.
  - idx NUM_REGS: INT_STATUS, write-1-to-clear.
  - idx NUM_REGS+1: INT_ENABLE, read/write.
  - Any other idx: writes ignored, reads return 0, transfer still acked.
  - Bits above NUM_REGS in INT_STATUS/INT_ENABLE read 0 and cannot be written.
- Handshake FSM states:
  - IDLE: on hit go to WAIT, loading the wait counter with WAIT_STATES.
  - WAIT: decrement the counter. When it is 0, go to ACK.
  - ACK: regbank_xferack=1 for exactly one cycle, then go to DONE.
  - DONE: stay until hba_select=0, then go to IDLE. This prevents a repeated ack when select is held.
- Latency: xferack is high in the cycle after WAIT_STATES+1 rising edges following the edge that sampled hit.
  - WAIT_STATES=0 gives xferack on the second edge.
- Address and rnw are latched in IDLE on hit. Later bus changes during the transfer are ignored.
- Write: commits on the same edge that raises xferack. reg_wr_strobe[idx] pulses in the same cycle as xferack.
  - A write to a read-only register is ignored: no strobe, but the transfer is still acked.
- Read: regbank_dbus is registered and presents the data only while xferack=1; it is 0 in all other cycles.
  - A read-only register returns the current reg_in slice.
- Change detection: each cycle, the read-only slices of reg_in are registered into a sample.
  - If slice i differs from its sample, INT_STATUS[i] sets on the next edge.
  - Read/write registers never set a status bit.
- Simultaneous W1C and a set event on the same bit: the set wins and the bit stays 1.
- regbank_interrupt is registered: it equals |(INT_STATUS & INT_ENABLE), one cycle after the status or enable change.

Decomposition:
- Shared package hba_pkg holds:
  - FSM state encoding (IDLE/WAIT/ACK/DONE);
  - INT_STATUS/INT_ENABLE offset functions of NUM_REGS;
  - a peripheral address-decode function shared with other HBA slaves.
- One sub-module, hba_slave_handshake, contains the decode, wait counter, FSM, latched idx/rnw and xferack. All HBA slaves reuse it.
- The register storage, read mux and interrupt logic stay in hba_reg_file.

Test Plan (PERIPH_ADDR=5, NUM_REGS=4, RO_MASK=4'b1000, WAIT_STATES=2):
1. Write 0x12 to abus=0x501:
   - xferack pulses once, on the fourth edge after select.
   - reg_wr_strobe=4'b0010 in that same cycle.
   - reg_out[15:8]=0x12.
   - Select held high afterwards gives no second ack.
2. Read abus=0x501 -> regbank_dbus=0x12 only in the xferack cycle and 0 before and after. Read abus=0x5FF -> 0x00, still acked.
3. Write 0x55 to 0x503 (read-only) with reg_in[31:24]=0xA5 -> no strobe, ack issued. A read of 0x503 returns 0xA5.
4. Write INT_ENABLE (0x505)=0x08, then change reg_in[31:24] to 0x3C:
   - INT_STATUS (0x504) reads 0x08.
   - regbank_interrupt=1.
   - Writing 0x08 to 0x504 clears the status and drops the interrupt one cycle later.
5. Change reg_in[31:24] on the same edge as the W1C write commits -> status stays 0x08 and the interrupt stays high.
6. Pull hba_reset low during WAIT of a write to 0x500 -> no ack, reg_out=0, and the FSM is in IDLE after release. Also, abus=0x401 selected -> no ack at all.

Source files
------------

// File: rtl/hba_pkg.sv
// Shared definitions for HBA slave peripherals. This package holds the handshake
// state encoding, the interrupt register offsets and the peripheral decode helper.
package hba_pkg;

  // Handshake FSM state encoding used by every HBA slave.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } hba_hs_state_t;

  // The wait counter holds WAIT_STATES, whose legal range is 0..15.
  localparam int WAIT_CNT_WIDTH = 4;

  // INT_STATUS sits directly after the data registers.
  function automatic int int_status_offset(input int num_regs);
    return num_regs;
  endfunction

  // INT_ENABLE follows INT_STATUS.
  function automatic int int_enable_offset(input int num_regs);
    return num_regs + 1;
  endfunction

  // A slave is addressed when a transfer is active and the peripheral field matches.
  function automatic logic periph_decode(input logic        select,
                                         input logic [31:0] periph_field,
                                         input logic [31:0] periph_addr);
    return select && (periph_field == periph_addr);
  endfunction

endpackage

// File: rtl/hba_slave_handshake.sv
// HBA slave handshake. It decodes the peripheral address, latches the register
// offset and direction, counts the wait states and produces a single xferack
// pulse for each transfer. o_commit is high in the cycle whose closing edge raises
// xferack, so the owner commits writes and registers read data on that edge.
module hba_slave_handshake
  import hba_pkg::*;
#(
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int WAIT_STATES       = 0
) (
  input  logic                      hba_clk,
  input  logic                      hba_reset,
  input  logic                      hba_select,
  input  logic                      hba_rnw,
  input  logic [ADDR_WIDTH-1:0]     hba_abus,
  output logic                      o_commit,
  output logic                      o_rnw,
  output logic [REG_ADDR_WIDTH-1:0] o_idx,
  output logic                      o_xferack
);

  logic                      w_hit;
  hba_hs_state_t             r_state;
  logic [WAIT_CNT_WIDTH-1:0] r_wait_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_idx;
  logic                      r_rnw;
  logic                      r_xferack;

  assign w_hit = periph_decode(hba_select,
                               32'(hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]),
                               32'(PERIPH_ADDR));

  // Handshake FSM: latch the transfer, count wait states, ack once, wait for deselect.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_rnw      <= 1'b0;
      r_xferack  <= 1'b0;
    end else begin
      r_xferack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_CNT_WIDTH'(WAIT_STATES);
            r_idx      <= hba_abus[REG_ADDR_WIDTH-1:0];
            r_rnw      <= hba_rnw;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state   <= ST_ACK;
            r_xferack <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Holding select must not start a second transfer.
          if (!hba_select) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_commit  = (r_state == ST_WAIT) && (r_wait_cnt == '0);
  assign o_rnw     = r_rnw;
  assign o_idx     = r_idx;
  assign o_xferack = r_xferack;

endmodule

// File: rtl/hba_reg_file.sv
// Parametrised HBA register bank. It has NUM_REGS data registers, each either
// read/write or read-only (fed by reg_in), plus INT_STATUS (write-1-to-clear) and
// INT_ENABLE. A change on a read-only input raises a maskable, registered interrupt.
// The read bus is zero except during a read ack, so it can be OR-combined with the
// buses of other slaves.
module hba_reg_file
  import hba_pkg::*;
#(
  parameter int                DBUS_WIDTH        = 8,
  parameter int                PERIPH_ADDR_WIDTH = 4,
  parameter int                REG_ADDR_WIDTH    = 8,
  parameter int                ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int                PERIPH_ADDR       = 0,
  parameter int                NUM_REGS          = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK         = '0,
  parameter int                WAIT_STATES       = 0
) (
  input  logic                           hba_clk,
  input  logic                           hba_reset,
  input  logic                           hba_rnw,
  input  logic                           hba_select,
  input  logic [ADDR_WIDTH-1:0]          hba_abus,
  input  logic [DBUS_WIDTH-1:0]          hba_dbus,
  output logic [DBUS_WIDTH-1:0]          regbank_dbus,
  output logic                           regbank_xferack,
  output logic                           regbank_interrupt,
  output logic [NUM_REGS*DBUS_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DBUS_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            reg_wr_strobe
);

  localparam int STAT_IDX = int_status_offset(NUM_REGS);
  localparam int EN_IDX   = int_enable_offset(NUM_REGS);

  logic                           w_commit;
  logic                           w_rnw;
  logic [REG_ADDR_WIDTH-1:0]      w_idx;
  logic                           w_wr;
  logic [NUM_REGS-1:0]            w_wr_sel;
  logic [NUM_REGS-1:0]            w_change;
  logic [NUM_REGS-1:0]            w_w1c;
  logic                           w_en_wr;
  logic [DBUS_WIDTH-1:0]          w_rd_data;
  logic                           w_unused;

  // Read-only slices of r_regs double as the change-detect sample of reg_in.
  logic [NUM_REGS*DBUS_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]            r_int_status;
  logic [NUM_REGS-1:0]            r_int_enable;
  logic                           r_irq;
  logic [NUM_REGS-1:0]            r_wr_strobe;
  logic [DBUS_WIDTH-1:0]          r_dbus;

  hba_slave_handshake #(
    .PERIPH_ADDR_WIDTH (PERIPH_ADDR_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .PERIPH_ADDR       (PERIPH_ADDR),
    .WAIT_STATES       (WAIT_STATES)
  ) u_handshake (
    .hba_clk    (hba_clk),
    .hba_reset  (hba_reset),
    .hba_select (hba_select),
    .hba_rnw    (hba_rnw),
    .hba_abus   (hba_abus),
    .o_commit   (w_commit),
    .o_rnw      (w_rnw),
    .o_idx      (w_idx),
    .o_xferack  (regbank_xferack)
  );

  assign w_wr = w_commit && !w_rnw;

  // Per-register write select and change detection.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign w_wr_sel[gi] = w_wr && !RO_MASK[gi] && (w_idx == REG_ADDR_WIDTH'(gi));
    assign w_change[gi] = RO_MASK[gi] &&
                          (reg_in[gi*DBUS_WIDTH +: DBUS_WIDTH] != r_regs[gi*DBUS_WIDTH +: DBUS_WIDTH]);
  end

  assign w_w1c   = (w_wr && (w_idx == REG_ADDR_WIDTH'(STAT_IDX))) ? hba_dbus[NUM_REGS-1:0] : '0;
  assign w_en_wr = w_wr && (w_idx == REG_ADDR_WIDTH'(EN_IDX));

  // Read mux over the latched offset; unmapped offsets read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == REG_ADDR_WIDTH'(i)) begin
        w_rd_data = RO_MASK[i] ? reg_in[i*DBUS_WIDTH +: DBUS_WIDTH]
                               : r_regs[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
    if (w_idx == REG_ADDR_WIDTH'(STAT_IDX)) begin
      w_rd_data = DBUS_WIDTH'(r_int_status);
    end
    if (w_idx == REG_ADDR_WIDTH'(EN_IDX)) begin
      w_rd_data = DBUS_WIDTH'(r_int_enable);
    end
  end

  // Register storage: read/write slices take bus writes, read-only slices sample reg_in.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i]) begin
          r_regs[i*DBUS_WIDTH +: DBUS_WIDTH] <= reg_in[i*DBUS_WIDTH +: DBUS_WIDTH];
        end else if (w_wr_sel[i]) begin
          r_regs[i*DBUS_WIDTH +: DBUS_WIDTH] <= hba_dbus;
        end
      end
    end
  end

  // Interrupt status/enable; a set event beats a simultaneous write-1-to-clear.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      r_int_status <= '0;
      r_int_enable <= '0;
    end else begin
      r_int_status <= (r_int_status & ~w_w1c) | w_change;
      if (w_en_wr) begin
        r_int_enable <= hba_dbus[NUM_REGS-1:0];
      end
    end
  end

  // Registered bus-side outputs: interrupt level, write strobes and read data.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      r_irq       <= 1'b0;
      r_wr_strobe <= '0;
      r_dbus      <= '0;
    end else begin
      r_irq       <= |(r_int_status & r_int_enable);
      r_wr_strobe <= w_wr_sel;
      r_dbus      <= (w_commit && w_rnw) ? w_rd_data : '0;
    end
  end

  // Read/write slices of reg_in are intentionally ignored.
  assign w_unused = ^reg_in;

  assign reg_out           = r_regs;
  assign reg_wr_strobe     = r_wr_strobe;
  assign regbank_dbus      = r_dbus;
  assign regbank_interrupt = r_irq;

endmodule
